// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// State enum, opcodes and the datapath select encodings.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_JAL    = 4'd9,
    S_JALR   = 4'd10,
    S_JALWB  = 4'd11,
    S_BRANCH = 4'd12,
    S_LUI    = 4'd13,
    S_AUIPC  = 4'd14,
    S_TRAP   = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  function automatic logic is_alu_op(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_ITYPE);
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Controller <-> datapath bundle: IR fields and flags in, selects/enables out.
interface riscv_mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             lt;
  logic             ltu;
  logic             mem_ready;
  logic             mem_req;
  logic             adrsrc;
  logic             irwrite;
  logic             pcwrite;
  logic             regwrite;
  logic             memwrite;
  logic [2:0]       immsrc;
  logic [1:0]       alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       resultsrc;
  logic [3:0]       alucontrol;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct3, funct7b5, zero, lt, ltu, mem_ready,
    output mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite,
           immsrc, alusrca, alusrcb, resultsrc, alucontrol, illegal, instret
  );

  modport slave (
    output op, funct3, funct7b5, zero, lt, ltu, mem_ready,
    input  mem_req, adrsrc, irwrite, pcwrite, regwrite, memwrite,
           immsrc, alusrca, alusrcb, resultsrc, alucontrol, illegal, instret
  );
endinterface

// File: rtl/riscv_alu_dec.sv
// ALU operation decode from IR fields and the controller's aluop request.
// Also reports whether a shift encoding is allowed in this build.
module riscv_alu_dec
  import riscv_mc_pkg::*;
#(
  parameter int SHIFT_EN = 1
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  aluop_t     aluop,
  output logic [3:0] alucontrol,
  output logic       shift_legal
);

  // funct3/funct7b5 table; funct7b5 on 000 means sub only for R-type
  always_comb begin
    alucontrol  = ALU_ADD;
    shift_legal = 1'b1;
    if ((SHIFT_EN == 0) && is_alu_op(op) && ((funct3 == 3'b001) || (funct3 == 3'b101))) begin
      shift_legal = 1'b0;
    end else begin
      shift_legal = 1'b1;
    end
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = ((op == OP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RV32I control unit with memory wait states, sticky illegal
// trap and a retired-instruction counter.
module riscv_mc_ctrl
  import riscv_mc_pkg::*;
#(
  parameter int MEM_HS   = 1,
  parameter int TRAP_EN  = 1,
  parameter int SHIFT_EN = 1,
  parameter int CNT_W    = 32
) (
  input logic             clk,
  input logic             reset,
  riscv_mc_ctrl_if.master bus
);

  state_t           state_r;
  state_t           next_state_s;
  logic             illegal_r;
  logic [CNT_W-1:0] instret_r;
  logic             ready_s;
  logic             taken_s;
  logic             legal_s;
  logic             shift_legal_s;
  logic             retire_s;
  logic [2:0]       imm_dec_s;
  aluop_t           aluop_s;
  logic             mem_req_s;
  logic             adrsrc_s;
  logic             irwrite_s;
  logic             pcwrite_s;
  logic             regwrite_s;
  logic             memwrite_s;
  logic [1:0]       alusrca_s;
  logic [1:0]       alusrcb_s;
  logic [1:0]       resultsrc_s;
  logic [3:0]       alucontrol_s;

  assign ready_s = (MEM_HS != 0) ? bus.mem_ready : 1'b1;

  riscv_alu_dec #(.SHIFT_EN(SHIFT_EN)) u_alu_dec (
    .op          (bus.op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .aluop       (aluop_s),
    .alucontrol  (alucontrol_s),
    .shift_legal (shift_legal_s)
  );

  // Branch condition, immediate format and encoding legality from the IR
  always_comb begin
    taken_s   = 1'b0;
    imm_dec_s = IMM_I;
    legal_s   = 1'b0;
    case (bus.funct3)
      3'b000:  taken_s = bus.zero;
      3'b001:  taken_s = ~bus.zero;
      3'b100:  taken_s = bus.lt;
      3'b101:  taken_s = ~bus.lt;
      3'b110:  taken_s = bus.ltu;
      3'b111:  taken_s = ~bus.ltu;
      default: taken_s = 1'b0;
    endcase
    case (bus.op)
      OP_STORE:         imm_dec_s = IMM_S;
      OP_BRANCH:        imm_dec_s = IMM_B;
      OP_JAL:           imm_dec_s = IMM_J;
      OP_LUI, OP_AUIPC: imm_dec_s = IMM_U;
      default:          imm_dec_s = IMM_I;
    endcase
    case (bus.op)
      OP_LOAD, OP_STORE:        legal_s = (bus.funct3 == 3'b010);
      OP_RTYPE, OP_ITYPE:       legal_s = shift_legal_s;
      OP_BRANCH:                legal_s = (bus.funct3 != 3'b010) && (bus.funct3 != 3'b011);
      OP_JALR:                  legal_s = (bus.funct3 == 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC: legal_s = 1'b1;
      default:                  legal_s = 1'b0;
    endcase
  end

  // Next state and Moore outputs; FETCH/BRANCH/EXEC add the listed input terms
  always_comb begin
    next_state_s = state_r;
    mem_req_s    = 1'b0;
    adrsrc_s     = 1'b0;
    irwrite_s    = 1'b0;
    pcwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    memwrite_s   = 1'b0;
    alusrca_s    = SRCA_PC;
    alusrcb_s    = SRCB_RS2;
    resultsrc_s  = RES_ALUOUT;
    aluop_s      = ALUOP_ADD;
    retire_s     = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        alusrcb_s    = SRCB_FOUR;
        resultsrc_s  = RES_ALURESULT;
        irwrite_s    = ready_s;
        pcwrite_s    = ready_s;
        next_state_s = ready_s ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrca_s = SRCA_OLDPC;
        alusrcb_s = SRCB_IMM;
        if (!legal_s) begin
          next_state_s = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
        end else begin
          case (bus.op)
            OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
            OP_RTYPE:          next_state_s = S_EXECR;
            OP_ITYPE:          next_state_s = S_EXECI;
            OP_JAL:            next_state_s = S_JAL;
            OP_JALR:           next_state_s = S_JALR;
            OP_BRANCH:         next_state_s = S_BRANCH;
            OP_LUI:            next_state_s = S_LUI;
            OP_AUIPC:          next_state_s = S_AUIPC;
            default:           next_state_s = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alusrca_s    = SRCA_RS1;
        alusrcb_s    = SRCB_IMM;
        next_state_s = (bus.op == OP_LOAD) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_s    = 1'b1;
        adrsrc_s     = 1'b1;
        next_state_s = ready_s ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        resultsrc_s  = RES_DATA;
        regwrite_s   = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_s    = 1'b1;
        adrsrc_s     = 1'b1;
        memwrite_s   = 1'b1;
        retire_s     = ready_s;
        next_state_s = ready_s ? S_FETCH : S_MEMWR;
      end
      S_EXECR: begin
        alusrca_s    = SRCA_RS1;
        aluop_s      = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_EXECI: begin
        alusrca_s    = SRCA_RS1;
        alusrcb_s    = SRCB_IMM;
        aluop_s      = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_s   = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        alusrca_s    = SRCA_OLDPC;
        alusrcb_s    = SRCB_FOUR;
        pcwrite_s    = 1'b1;
        next_state_s = S_ALUWB;
      end
      S_JALR: begin
        alusrca_s    = SRCA_RS1;
        alusrcb_s    = SRCB_IMM;
        resultsrc_s  = RES_ALURESULT;
        pcwrite_s    = 1'b1;
        next_state_s = S_JALWB;
      end
      S_JALWB: begin
        alusrca_s    = SRCA_OLDPC;
        alusrcb_s    = SRCB_FOUR;
        resultsrc_s  = RES_ALURESULT;
        regwrite_s   = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_s    = SRCA_RS1;
        aluop_s      = ALUOP_SUB;
        pcwrite_s    = taken_s;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_LUI: begin
        resultsrc_s  = RES_IMM;
        regwrite_s   = 1'b1;
        retire_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_AUIPC: begin
        alusrca_s    = SRCA_OLDPC;
        alusrcb_s    = SRCB_IMM;
        next_state_s = S_ALUWB;
      end
      S_TRAP: begin
        next_state_s = S_TRAP;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // State, sticky trap flag and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
      instret_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (next_state_s == S_TRAP) begin
        illegal_r <= 1'b1;
      end
      if (retire_s) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Enables are blocked for the whole reset cycle so an abandoned access never writes
  assign bus.mem_req    = mem_req_s  & ~reset;
  assign bus.irwrite    = irwrite_s  & ~reset;
  assign bus.pcwrite    = pcwrite_s  & ~reset;
  assign bus.regwrite   = regwrite_s & ~reset;
  assign bus.memwrite   = memwrite_s & ~reset;
  assign bus.adrsrc     = adrsrc_s;
  assign bus.immsrc     = imm_dec_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.resultsrc  = resultsrc_s;
  assign bus.alucontrol = alucontrol_s;
  assign bus.illegal    = illegal_r;
  assign bus.instret    = instret_r;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Bench for riscv_mc_ctrl: three parameter sets share stimulus; an
// instruction-level model predicts each cycle's control outputs and instret.
module tb_riscv_mc_ctrl;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
  localparam logic [6:0] T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;
  localparam logic [6:0] T_BAD = 7'b1111111;

  typedef struct {
    logic [19:0] exp;
    logic [19:0] care;
  } phase_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7b5 = 1'b0, zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

  riscv_mc_ctrl_if #(.CNT_W(32)) bus0 ();
  riscv_mc_ctrl_if #(.CNT_W(32)) bus1 ();
  riscv_mc_ctrl_if #(.CNT_W(4))  bus2 ();

  riscv_mc_ctrl #(.MEM_HS(1), .TRAP_EN(1), .SHIFT_EN(1), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  riscv_mc_ctrl #(.MEM_HS(1), .TRAP_EN(1), .SHIFT_EN(0), .CNT_W(32)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  riscv_mc_ctrl #(.MEM_HS(0), .TRAP_EN(0), .SHIFT_EN(0), .CNT_W(4))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign {bus0.op, bus0.funct3, bus0.funct7b5, bus0.zero, bus0.lt, bus0.ltu, bus0.mem_ready} = {op, funct3, funct7b5, zero, lt, ltu, mem_ready};
  assign {bus1.op, bus1.funct3, bus1.funct7b5, bus1.zero, bus1.lt, bus1.ltu, bus1.mem_ready} = {op, funct3, funct7b5, zero, lt, ltu, mem_ready};
  assign {bus2.op, bus2.funct3, bus2.funct7b5, bus2.zero, bus2.lt, bus2.ltu, bus2.mem_ready} = {op, funct3, funct7b5, zero, lt, ltu, mem_ready};

  logic [19:0] out_vec [3];
  logic [31:0] cnt [3];
  assign out_vec[0] = {bus0.mem_req, bus0.adrsrc, bus0.irwrite, bus0.pcwrite, bus0.regwrite, bus0.memwrite,
                       bus0.immsrc, bus0.alusrca, bus0.alusrcb, bus0.resultsrc, bus0.alucontrol, bus0.illegal};
  assign out_vec[1] = {bus1.mem_req, bus1.adrsrc, bus1.irwrite, bus1.pcwrite, bus1.regwrite, bus1.memwrite,
                       bus1.immsrc, bus1.alusrca, bus1.alusrcb, bus1.resultsrc, bus1.alucontrol, bus1.illegal};
  assign out_vec[2] = {bus2.mem_req, bus2.adrsrc, bus2.irwrite, bus2.pcwrite, bus2.regwrite, bus2.memwrite,
                       bus2.immsrc, bus2.alusrca, bus2.alusrcb, bus2.resultsrc, bus2.alucontrol, bus2.illegal};
  assign cnt[0] = bus0.instret;
  assign cnt[1] = bus1.instret;
  assign cnt[2] = {28'd0, bus2.instret};

  always #5 clk = ~clk;

  int cfg_hs [3] = '{1, 1, 0};
  int cfg_trap [3] = '{1, 1, 0};
  int cfg_shift [3] = '{1, 0, 0};
  logic [31:0] cnt_mask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};
  logic [6:0] ops [10] = '{T_LOAD, T_STORE, T_R, T_I, T_BR, T_JAL, T_JALR, T_LUI, T_AUIPC, T_BAD};

  int cur = 0;
  int n_checks = 0;
  int n_err = 0;
  logic [31:0] model_cnt = 32'd0;
  bit trapped = 1'b0;

  // adr, imm, a, b, rs, alu < 0 mean "don't care"; enables and illegal always checked
  function automatic phase_t ph(int adr, int imm, int a, int b, int rs, int alu,
                                int mreq, int irw, int pcw, int rw, int mw, int ill);
    phase_t p;
    p.exp  = 20'd0;
    p.care = 20'hBC001;
    p.exp[19] = mreq[0]; p.exp[17] = irw[0]; p.exp[16] = pcw[0];
    p.exp[15] = rw[0];   p.exp[14] = mw[0];  p.exp[0]  = ill[0];
    if (adr >= 0) begin p.exp[18] = adr[0];       p.care[18]    = 1'b1;   end
    if (imm >= 0) begin p.exp[13:11] = imm[2:0];  p.care[13:11] = 3'b111; end
    if (a >= 0)   begin p.exp[10:9] = a[1:0];     p.care[10:9]  = 2'b11;  end
    if (b >= 0)   begin p.exp[8:7] = b[1:0];      p.care[8:7]   = 2'b11;  end
    if (rs >= 0)  begin p.exp[6:5] = rs[1:0];     p.care[6:5]   = 2'b11;  end
    if (alu >= 0) begin p.exp[4:1] = alu[3:0];    p.care[4:1]   = 4'hF;   end
    return p;
  endfunction

  function automatic bit legal(logic [6:0] o, logic [2:0] f3);
    case (o)
      T_LOAD, T_STORE:     return f3 == 3'd2;
      T_R, T_I:            return (cfg_shift[cur] != 0) || !((f3 == 3'd1) || (f3 == 3'd5));
      T_BR:                return (f3 != 3'd2) && (f3 != 3'd3);
      T_JALR:              return f3 == 3'd0;
      T_JAL, T_LUI, T_AUIPC: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic int imm_exp(logic [6:0] o);
    case (o)
      T_STORE:         return 1;
      T_BR:            return 2;
      T_JAL:           return 3;
      T_LUI, T_AUIPC:  return 4;
      T_R:             return -1;
      default:         return 0;
    endcase
  endfunction

  function automatic int alu_exp(logic [6:0] o, logic [2:0] f3, logic f7);
    case (f3)
      3'd0: return (o == T_R && f7) ? 1 : 0;
      3'd1: return 7;
      3'd2: return 5;
      3'd3: return 6;
      3'd4: return 4;
      3'd5: return f7 ? 9 : 8;
      3'd6: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit taken(logic [2:0] f3);
    case (f3)
      3'd0: return zero;
      3'd1: return !zero;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input phase_t p, input string nm, input bit ret);
    @(negedge clk);
    n_checks++;
    if ((out_vec[cur] & p.care) !== (p.exp & p.care)) begin
      n_err++;
      $display("FAIL %s cfg%0d t=%0t: outputs %h required %h (mask %h)", nm, cur, $time,
               out_vec[cur] & p.care, p.exp & p.care, p.care);
    end
    n_checks++;
    if (cnt[cur] !== model_cnt) begin
      n_err++;
      $display("FAIL instret@%s cfg%0d t=%0t: got %0d required %0d", nm, cur, $time, cnt[cur], model_cnt);
    end
    @(posedge clk);
    #1;
    if (ret) model_cnt = (model_cnt + 32'd1) & cnt_mask[cur];
  endtask

  task automatic plain(input phase_t p, input string nm, input bit ret);
    mem_ready = 1'($urandom_range(0, 1));
    step(p, nm, ret);
  endtask

  // w >= 0: exactly w not-ready cycles; w < 0: random wait
  task automatic mem_phase(input phase_t p, input string nm, input int w, input bit ret_on_ready,
                           inout int cyc, input bit is_fetch);
    int n = 0;
    bit eff;
    phase_t q;
    do begin
      mem_ready = (w >= 0) ? (n >= w) : ((n >= 4) || ($urandom_range(0, 2) != 0));
      eff = (cfg_hs[cur] != 0) ? mem_ready : 1'b1;
      q = p;
      if (is_fetch) begin q.exp[17] = eff; q.exp[16] = eff; end
      step(q, nm, ret_on_ready && eff);
      cyc++;
      n++;
    end while (!eff);
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fw, input int mw, output int cyc);
    phase_t aluwb;
    bit ok;
    op = o; funct3 = f3; funct7b5 = f7;
    cyc = 0;
    trapped = 1'b0;
    aluwb = ph(-1, -1, -1, -1, 0, -1, 0, 0, 0, 1, 0, 0);
    mem_phase(ph(0, -1, 0, 2, 2, 0, 1, 0, 0, 0, 0, 0), "fetch", fw, 1'b0, cyc, 1'b1);
    ok = legal(o, f3);
    plain(ph(-1, ok ? imm_exp(o) : -1, 1, 1, -1, 0, 0, 0, 0, 0, 0, 0), "decode", 1'b0);
    cyc++;
    if (!ok) begin
      if (cfg_trap[cur] != 0) begin
        trapped = 1'b1;
        repeat (3) begin
          plain(ph(-1, -1, -1, -1, -1, -1, 0, 0, 0, 0, 0, 1), "trap", 1'b0);
          cyc++;
        end
      end
      return;
    end
    case (o)
      T_LOAD: begin
        plain(ph(-1, -1, 2, 1, -1, 0, 0, 0, 0, 0, 0, 0), "memadr", 1'b0); cyc++;
        mem_phase(ph(1, -1, -1, -1, 0, -1, 1, 0, 0, 0, 0, 0), "memrd", mw, 1'b0, cyc, 1'b0);
        plain(ph(-1, -1, -1, -1, 1, -1, 0, 0, 0, 1, 0, 0), "memwb", 1'b1); cyc++;
      end
      T_STORE: begin
        plain(ph(-1, -1, 2, 1, -1, 0, 0, 0, 0, 0, 0, 0), "memadr", 1'b0); cyc++;
        mem_phase(ph(1, -1, -1, -1, 0, -1, 1, 0, 0, 0, 1, 0), "memwr", mw, 1'b1, cyc, 1'b0);
      end
      T_R: begin
        plain(ph(-1, -1, 2, 0, -1, alu_exp(o, f3, f7), 0, 0, 0, 0, 0, 0), "execr", 1'b0); cyc++;
        plain(aluwb, "aluwb", 1'b1); cyc++;
      end
      T_I: begin
        plain(ph(-1, -1, 2, 1, -1, alu_exp(o, f3, f7), 0, 0, 0, 0, 0, 0), "execi", 1'b0); cyc++;
        plain(aluwb, "aluwb", 1'b1); cyc++;
      end
      T_JAL: begin
        plain(ph(-1, -1, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0), "jal", 1'b0); cyc++;
        plain(aluwb, "aluwb", 1'b1); cyc++;
      end
      T_JALR: begin
        plain(ph(-1, -1, 2, 1, 2, 0, 0, 0, 1, 0, 0, 0), "jalr", 1'b0); cyc++;
        plain(ph(-1, -1, 1, 2, 2, 0, 0, 0, 0, 1, 0, 0), "jalwb", 1'b1); cyc++;
      end
      T_BR: begin
        plain(ph(-1, -1, 2, 0, 0, 1, 0, 0, int'(taken(f3)), 0, 0, 0), "branch", 1'b1); cyc++;
      end
      T_LUI: begin
        plain(ph(-1, 4, -1, -1, 3, -1, 0, 0, 0, 1, 0, 0), "lui", 1'b1); cyc++;
      end
      default: begin
        plain(ph(-1, 4, 1, 1, -1, 0, 0, 0, 0, 0, 0, 0), "auipc", 1'b0); cyc++;
        plain(aluwb, "aluwb", 1'b1); cyc++;
      end
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    op = T_R;
    @(negedge clk);
    n_checks++;
    if ((out_vec[cur] & 20'hBC000) !== 20'd0) begin
      n_err++;
      $display("FAIL reset_enables cfg%0d: got %h required 00000", cur, out_vec[cur] & 20'hBC000);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({out_vec[cur][0], cnt[cur]} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_state cfg%0d: illegal %b instret %0d required 0 0", cur, out_vec[cur][0], cnt[cur]);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_cnt = 32'd0;
  endtask

  task automatic rand_instr(output logic [6:0] o, output logic [2:0] f3, output logic f7);
    o = ops[$urandom_range(0, 9)];
    f3 = 3'($urandom_range(0, 7));
    if ((o == T_LOAD || o == T_STORE) && $urandom_range(0, 7) != 0) f3 = 3'd2;
    if (o == T_JALR && $urandom_range(0, 7) != 0) f3 = 3'd0;
    f7 = 1'($urandom_range(0, 1));
    {zero, lt, ltu} = 3'($urandom_range(0, 7));
  endtask

  task automatic check_cyc(input string nm, input int got, input int req);
    n_checks++;
    if (got !== req) begin
      n_err++;
      $display("FAIL cycles_%s cfg%0d: got %0d required %0d", nm, cur, got, req);
    end
  endtask

  task automatic test_reset();
    cur = 0;
    do_reset();
  endtask

  task automatic test_add();
    int c;
    cur = 0;
    do_reset();
    {zero, lt, ltu} = 3'b000;
    run_instr(T_R, 3'd0, 1'b0, 0, 0, c);
    check_cyc("add", c, 4);
  endtask

  task automatic test_mem_waits();
    int c;
    cur = 0;
    run_instr(T_LOAD, 3'd2, 1'b0, 2, 3, c);
    check_cyc("lw_wait", c, 10);
    run_instr(T_STORE, 3'd2, 1'b0, 0, 2, c);
    check_cyc("sw_wait", c, 6);
  endtask

  task automatic test_branch();
    int c;
    cur = 0;
    {zero, lt, ltu} = 3'b001;
    run_instr(T_BR, 3'd6, 1'b0, 0, 0, c);
    check_cyc("bltu", c, 3);
    {zero, lt, ltu} = 3'b010;
    run_instr(T_BR, 3'd5, 1'b0, 0, 0, c);
    check_cyc("bge", c, 3);
  endtask

  task automatic test_jalr_lui();
    int c;
    cur = 0;
    run_instr(T_JALR, 3'd0, 1'b0, 0, 0, c);
    check_cyc("jalr", c, 4);
    run_instr(T_LUI, 3'd3, 1'b0, 0, 0, c);
    check_cyc("lui", c, 3);
  endtask

  task automatic test_shift();
    int c;
    cur = 0;
    run_instr(T_I, 3'd5, 1'b1, 0, 0, c);
    check_cyc("srai", c, 4);
    cur = 1;
    do_reset();
    run_instr(T_R, 3'd4, 1'b0, 0, 0, c);
    run_instr(T_I, 3'd5, 1'b1, 0, 0, c);
    check_cyc("srai_trap", c, 5);
    n_checks++;
    if ({out_vec[1][0], cnt[1]} !== {1'b1, 32'd1}) begin
      n_err++;
      $display("FAIL trap_sticky cfg1: illegal %b instret %0d required 1 1", out_vec[1][0], cnt[1]);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    cur = 0;
    do_reset();
    op = T_STORE; funct3 = 3'd2; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_vec[0][19], out_vec[0][14]} !== 2'b11) begin
      n_err++;
      $display("FAIL memwr_wait: req/we %b required 11", {out_vec[0][19], out_vec[0][14]});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_vec[0][19], out_vec[0][14]} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_mid_block: req/we %b required 00", {out_vec[0][19], out_vec[0][14]});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_cnt = 32'd0;
    @(negedge clk);
    n_checks++;
    if ({out_vec[0][19], out_vec[0][14], cnt[0]} !== {2'b10, 32'd0}) begin
      n_err++;
      $display("FAIL reset_mid_fetch: req/we %b instret %0d required 10 0", {out_vec[0][19], out_vec[0][14]}, cnt[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_nop_nohs();
    int c;
    cur = 2;
    do_reset();
    run_instr(T_BAD, 3'd0, 1'b0, 0, 0, c);
    check_cyc("nop", c, 2);
    run_instr(T_LOAD, 3'd2, 1'b0, 2, 3, c);
    check_cyc("lw_nohs", c, 5);
  endtask

  task automatic test_random(input int which, input int n);
    int c;
    logic [6:0] o;
    logic [2:0] f3;
    logic f7;
    cur = which;
    do_reset();
    for (int i = 0; i < n; i++) begin
      rand_instr(o, f3, f7);
      run_instr(o, f3, f7, -1, -1, c);
      if (trapped) do_reset();
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_mem_waits();
    test_branch();
    test_jalr_lui();
    test_shift();
    test_reset_mid();
    test_nop_nohs();
    test_random(2, 40);
    test_random(0, 60);
    test_random(1, 30);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
- Parametrised multicycle RV32I control unit. Drives the existing multicycle datapath through the usual mux selects and write enables.
- Extends the single-cycle-memory controller with:
  - full branch set (beq/bne/blt/bge/bltu/bgeu), jalr, lui, auipc, shifts/xor/sltu;
  - memory ready handshake (wait states);
  - sticky illegal-instruction trap;
  - retired-instruction counter.

Parameters:
- MEM_HS, 1, 1: honour mem_ready; 0: mem_ready treated as constant 1.
- TRAP_EN, 1, 1: illegal encodings enter TRAP; 0: they return to FETCH, no register or memory write (NOP).
- SHIFT_EN, 1, 1: sll/srl/sra legal; 0: funct3 001/101 on R/I-ALU ops are illegal.
- CNT_W, 32, width of instret counter.

Ports:
- clk, in, 1, clock
- reset, in, 1, synchronous active-high reset
- op, in, 7, instr[6:0] from IR
- funct3, in, 3, instr[14:12]
- funct7b5, in, 1, instr[30]
- zero, in, 1, ALU result == 0
- lt, in, 1, signed A<B from ALU subtract
- ltu, in, 1, unsigned A<B from ALU subtract
- mem_ready, in, 1, memory completes current access this cycle
- mem_req, out, 1, memory access active
- adrsrc, out, 1, 0 = PC, 1 = Result
- irwrite, pcwrite, regwrite, memwrite, out, 1 each
- immsrc, out, 3: 000 I, 001 S, 010 B, 011 J, 100 U
- alusrca, out, 2: 00 PC, 01 OldPC, 10 rs1
- alusrcb, out, 2: 00 rs2, 01 ImmExt, 10 const 4
- resultsrc, out, 2: 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- alucontrol, out, 4: add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sltu 0110, sll 0111, srl 1000, sra 1001
- illegal, out, 1, sticky trap flag
- instret, out, CNT_W, retired-instruction count

Behaviour:
- Clocking/reset:
  - One clock. Reset is synchronous and active-high. Ports are named clk and reset.
  - While reset is high: state <= FETCH, illegal <= 0, instret <= 0, all write enables and mem_req forced to 0.
- Outputs: Moore from state, except:
  - irwrite/pcwrite in FETCH are gated by mem_ready;
  - pcwrite in BRANCH depends on the branch condition;
  - alucontrol in EXECR/EXECI depends on funct3/funct7b5.
- Per-state outputs (unlisted fields: 0 or don't-care):
  - FETCH: mem_req=1, adrsrc=0, A=PC, B=4, add, resultsrc=10, irwrite=pcwrite=mem_ready. Stay in FETCH until mem_ready, then DECODE.
  - DECODE: A=OldPC, B=Imm, add. immsrc from op. Computes the branch/jal target into ALUOut.
  - MEMADR: A=rs1, B=Imm, add. Go to MEMRD (lw) or MEMWR (sw).
  - MEMRD: mem_req=1, adrsrc=1, resultsrc=00. Wait for mem_ready, then MEMWB.
  - MEMWB: resultsrc=01, regwrite=1. Then FETCH.
  - MEMWR: mem_req=1, adrsrc=1, resultsrc=00, memwrite=1. memwrite is held every cycle until mem_ready, then FETCH.
  - EXECR: A=rs1, B=rs2. Then ALUWB.
  - EXECI: A=rs1, B=Imm. Then ALUWB.
  - ALUWB: resultsrc=00, regwrite=1. Then FETCH.
  - JAL: A=OldPC, B=4, add, resultsrc=00, pcwrite=1. Then ALUWB.
  - JALR: A=rs1, B=Imm, add, resultsrc=10, pcwrite=1. Then JALWB.
  - JALWB: A=OldPC, B=4, add, resultsrc=10, regwrite=1. Then FETCH.
  - BRANCH: A=rs1, B=rs2, sub, resultsrc=00, pcwrite=taken. Then FETCH.
    - Taken by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - LUI: immsrc=U, resultsrc=11, regwrite=1. Then FETCH.
  - AUIPC: immsrc=U, A=OldPC, B=Imm, add. Then ALUWB.
  - TRAP: all enables 0, illegal=1. Only reset exits.
- ALU decode (EXECR/EXECI), by funct3:
  - 000: sub if R-type and funct7b5, else add.
  - 001 sll; 010 slt; 011 sltu; 100 xor.
  - 101: sra if funct7b5, else srl (applies to both R and I).
  - 110 or; 111 and.
- Illegal conditions, decided in DECODE:
  - unknown op;
  - lw/sw with funct3 != 010;
  - branch funct3 010/011;
  - jalr funct3 != 000;
  - shifts when SHIFT_EN=0.
- Cycle counts with mem_ready=1:
  - lui, branch: 3
  - R, I, jal, jalr, auipc, sw: 4
  - lw: 5
  - Each mem_ready=0 cycle adds one.
- instret:
  - Increments by 1 on each retiring cycle: MEMWB, ALUWB, JALWB, BRANCH, LUI, and MEMWR with mem_ready.
  - Wraps modulo 2^CNT_W.
  - Not incremented for trapped or NOP'd illegal instructions.
- Reset mid-instruction (including during a wait state): abandons it with no write; next cycle is FETCH.

Decomposition:
- Package riscv_mc_pkg holds:
  - state enum;
  - opcode constants;
  - alucontrol, immsrc, alusrca/b and resultsrc encodings.
- Sub-module riscv_alu_dec: combinational op/funct3/funct7b5/aluop -> alucontrol plus shift-legal flag.
- Branch-condition and immsrc decode live in the top module.

Test Plan:
- Reset, then add x3,x1,x2 with mem_ready=1:
  - states FETCH, DECODE, EXECR, ALUWB;
  - regwrite=1 on cycle 4 only;
  - alucontrol=0000;
  - instret 0 -> 1.
- lw with mem_ready low 2 cycles in FETCH and 3 in MEMRD:
  - total 10 cycles;
  - irwrite/pcwrite pulse once on the ready cycle;
  - regwrite once in MEMWB.
- sw with mem_ready low 2 cycles in MEMWR: memwrite high for 3 cycles, then FETCH; instret +1.
- bltu with ltu=1 -> pcwrite=1 in BRANCH. bge with lt=1 -> pcwrite=0. Both 3 cycles.
- srai (funct3=101, funct7b5=1) -> alucontrol=1001. With SHIFT_EN=0, TRAP_EN=1: illegal=1, enables stay 0 until reset; instret unchanged.
- jalr then lui:
  - JALR: pcwrite=1 with resultsrc=10; JALWB: regwrite=1 with A=01, B=10.
  - LUI: resultsrc=11, regwrite=1.
  - instret +2.
